// File: rtl/count_display_7seg.sv
// Binary-to-BCD converter (sequential double-dabble) driving a 4-digit multiplexed 7-seg display.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module count_display_7seg #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned REFRESH_HZ = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  count,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [11:0] bcd,
    output logic        busy
);

    localparam int unsigned SCAN_DIV = CLK_HZ / REFRESH_HZ;
    localparam int unsigned PW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e        state_q, state_d;
    logic [19:0]   sr_q, sr_d, adj;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    latch_q, latch_d;
    logic [7:0]    shown_q, shown_d;
    logic [11:0]   bcd_q, bcd_d;
    logic          busy_q, busy_d;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_q, digit_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          tick;
    logic          blank_h, blank_t;

    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'd0:    dec7 = 7'b1000000;
            4'd1:    dec7 = 7'b1111001;
            4'd2:    dec7 = 7'b0100100;
            4'd3:    dec7 = 7'b0110000;
            4'd4:    dec7 = 7'b0011001;
            4'd5:    dec7 = 7'b0010010;
            4'd6:    dec7 = 7'b0000010;
            4'd7:    dec7 = 7'b1111000;
            4'd8:    dec7 = 7'b0000000;
            4'd9:    dec7 = 7'b0010000;
            default: dec7 = 7'b1111111;
        endcase
    endfunction

    // Add-3 correction on each BCD nibble before the shift.
    always_comb begin
        adj = sr_q;
        for (int i = 0; i < 3; i++) begin
            if (sr_q[8+4*i +: 4] >= 4'd5) begin
                adj[8+4*i +: 4] = sr_q[8+4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bitcnt_d = bitcnt_q;
        latch_d  = latch_q;
        shown_d  = shown_q;
        bcd_d    = bcd_q;
        busy_d   = busy_q;
        unique case (state_q)
            StIdle: begin
                if (count != shown_q) begin
                    sr_d     = {12'd0, count};
                    latch_d  = count;
                    bitcnt_d = 3'd0;
                    busy_d   = 1'b1;
                    state_d  = StShift;
                end
            end
            StShift: begin
                sr_d     = adj << 1;
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bcd_d   = sr_q[19:8];
                shown_d = latch_q;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            sr_q     <= '0;
            bitcnt_q <= '0;
            latch_q  <= '0;
            shown_q  <= '0;
            bcd_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            bitcnt_q <= bitcnt_d;
            latch_q  <= latch_d;
            shown_q  <= shown_d;
            bcd_q    <= bcd_d;
            busy_q   <= busy_d;
        end
    end

    assign tick = (presc_q == PW'(SCAN_DIV - 1));

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_h = (bcd_d[11:8] == 4'd0);
    assign blank_t = (bcd_d[11:8] == 4'd0) && (bcd_d[7:4] == 4'd0);
`else
    assign blank_h = 1'b0;
    assign blank_t = 1'b0;
`endif

    // Decode from bcd_d so a conversion landing on a tick edge shows immediately.
    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        digit_d = digit_q;
        an_d    = an_q;
        seg_d   = seg_q;
        if (tick) begin
            digit_d = digit_q + 2'd1;
            an_d    = ~(4'b0001 << digit_q);
            unique case (digit_q)
                2'd0:    seg_d = dec7(bcd_d[3:0]);
                2'd1:    seg_d = blank_t ? 7'b1111111 : dec7(bcd_d[7:4]);
                2'd2:    seg_d = blank_h ? 7'b1111111 : dec7(bcd_d[11:8]);
                default: seg_d = 7'b1111111;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            digit_q <= '0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
        end else begin
            presc_q <= presc_d;
            digit_q <= digit_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = 1'b1;
    assign bcd  = bcd_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_count_display_7seg.sv
// Scoreboard bench for count_display_7seg: conversions checked on busy fall, scan checked per digit.
module tb_count_display_7seg;

    localparam int unsigned SCAN_DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  count = 8'h00;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [11:0] bcd;
    logic        busy;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [11:0] exp_q[$];
    logic [11:0] model_bcd = 12'h000;
    bit          disp_chk = 1'b0;

    count_display_7seg #(
        .CLK_HZ    (16),
        .REFRESH_HZ(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .count(count),
        .an   (an),
        .seg  (seg),
        .dp   (dp),
        .bcd  (bcd),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    endtask

    function automatic logic [6:0] digit7(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] ref_seg(input logic [3:0] a, input logic [11:0] b);
        case (a)
            4'b1110: return digit7(b[3:0]);
            4'b1101: return (LZB && b[11:8] == 4'd0 && b[7:4] == 4'd0) ? 7'h7f : digit7(b[7:4]);
            4'b1011: return (LZB && b[11:8] == 4'd0) ? 7'h7f : digit7(b[11:8]);
            default: return 7'h7f;
        endcase
    endfunction

    // Conversion monitor: each busy fall pops one expected bcd.
    int   hi_cnt = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            hi_cnt    = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) hi_cnt++;
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_conversion", 32'(bcd), 32'hFFFF_FFFF);
                end else begin
                    check("bcd", 32'(bcd), 32'(exp_q.pop_front()));
                    check("busy_len", 32'(hi_cnt), 32'd9);
                end
                hi_cnt = 0;
            end
            prev_busy = busy;
        end
    end

    // Scan monitor: digit rotation, hold time and segments against model_bcd.
    logic [3:0] prev_an = 4'hf;
    int         hold = 0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_an = 4'hf;
            hold    = 0;
        end else if (an != prev_an) begin
            if (disp_chk) begin
                check("an_rotate", 32'(an),
                      (prev_an == 4'hf) ? 32'hE : 32'({prev_an[2:0], prev_an[3]}));
                if (prev_an != 4'hf) check("digit_hold", 32'(hold), 32'(SCAN_DIV));
                check("seg", 32'(seg), 32'(ref_seg(an, model_bcd)));
                check("dp", 32'(dp), 32'd1);
            end
            prev_an = an;
            hold    = 1;
        end else begin
            hold++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !busy) break;
        end
        if (k == 80) begin
            n_total++;
            $display("FAIL %s_timeout: got %0d pending, expected 0 pending", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic show(input logic [11:0] b, input int n);
        model_bcd = b;
        disp_chk  = 1'b1;
        cycles(n);
        disp_chk  = 1'b0;
    endtask

    initial begin
        // Reset state
        cycles(3);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bcd", 32'(bcd), 32'h000);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (k < 4) begin
                check("pre_tick_an", 32'(an), 32'hF);
            end else begin
                check("first_tick_an", 32'(an), 32'hE);
                check("first_tick_seg", 32'(seg), 32'h40);
            end
        end
        check("idle_busy", 32'(busy), 32'd0);
        show(12'h000, 12);

        // Full-scale conversion
        count = 8'hFF;
        exp_q.push_back(12'h255);
        wait_done("full_scale");
        show(12'h255, 8 * SCAN_DIV);

        // Count changes mid-conversion
        count = 8'h64;
        exp_q.push_back(12'h100);
        exp_q.push_back(12'h042);
        cycles(3);
        count = 8'h2A;
        wait_done("mid_change");
        show(12'h042, 6 * SCAN_DIV);

        // Leading zeros
        count = 8'h07;
        exp_q.push_back(12'h007);
        wait_done("lead_zero");
        show(12'h007, 8 * SCAN_DIV);

        // Reset during SHIFT
        count = 8'hFF;
        exp_q.push_back(12'h255);
        wait_done("pre_abort");
        check("pre_abort_bcd", 32'(bcd), 32'h255);
        count = 8'h0C;
        cycles(3);
        #2 rst = 1'b0;
        #1;
        check("abort_an", 32'(an), 32'hF);
        check("abort_seg", 32'(seg), 32'h7F);
        check("abort_bcd", 32'(bcd), 32'h000);
        check("abort_busy", 32'(busy), 32'd0);
        cycles(3);
        exp_q.push_back(12'h012);
        rst = 1'b1;
        wait_done("after_abort");
        show(12'h012, 8 * SCAN_DIV);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
